// File: rtl/isa_pkg.sv
// ISA constants, field positions and FSM state encoding
// shared by the fetch/decode sequencer and its field decoder.
package isa_pkg;

  localparam int ILEN          = 16;
  localparam int FETCH_TIMEOUT = 8;
  localparam int TO_W          = $clog2(FETCH_TIMEOUT + 1);

  localparam logic [3:0] OP_LD     = 4'h0;
  localparam logic [3:0] OP_ST     = 4'h1;
  localparam logic [3:0] OP_ALU_LO = 4'h2;
  localparam logic [3:0] OP_ALU_HI = 4'h8;
  localparam logic [3:0] OP_BEQ    = 4'hB;
  localparam logic [3:0] OP_BNE    = 4'hC;
  localparam logic [3:0] OP_JMP    = 4'hD;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 9;
  localparam int RB_HI  = 8;
  localparam int RB_LO  = 6;
  localparam int RC_HI  = 5;
  localparam int RC_LO  = 3;
  localparam int IMM_HI = 5;
  localparam int J_HI   = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_CLR,
    S_FETCH_REQ,
    S_DECODE,
    S_EXEC,
    S_BR_EVAL,
    S_REDIRECT,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [2:0] rd;
    logic [5:0] imm6;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } fld_t;

  typedef struct packed {
    fld_t fld;
    logic is_branch;
    logic is_bne;
    logic is_jump;
    logic is_illegal;
  } dec_t;

endpackage

// File: rtl/instr_decode_ctrl_if.sv
// Instruction memory port: fetch/reset strobes, returned word
// and the branch/jump PC-redirect handshake.
interface instr_decode_ctrl_if;
  import isa_pkg::*;

  logic            read_instruction;
  logic            reset_imem;
  logic [ILEN-1:0] imem_instr;
  logic            imem_complete;
  logic            imem_pc_set;
  logic            branch_execute;
  logic            jump_execute;
  logic [5:0]      branch_offset;
  logic [11:0]     jump_offset;

  modport master (
    output read_instruction,
    output reset_imem,
    output branch_execute,
    output jump_execute,
    output branch_offset,
    output jump_offset,
    input  imem_instr,
    input  imem_complete,
    input  imem_pc_set
  );

  modport slave (
    input  read_instruction,
    input  reset_imem,
    input  branch_execute,
    input  jump_execute,
    input  branch_offset,
    input  jump_offset,
    output imem_instr,
    output imem_complete,
    output imem_pc_set
  );

endinterface

// File: rtl/instr_field_decode.sv
// Combinational map from instruction word to control fields.
// Fields an opcode does not use stay 0.
module instr_field_decode
  import isa_pkg::*;
(
  input  logic [ILEN-1:0] ir_i,
  output dec_t            dec_o
);

  logic [3:0] op;
  logic       is_ld;
  logic       is_st;
  logic       is_alu;
  logic       is_br;
  logic       is_jmp;

  assign op     = ir_i[OP_HI:OP_LO];
  assign is_ld  = (op == OP_LD);
  assign is_st  = (op == OP_ST);
  assign is_alu = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jmp = (op == OP_JMP);

  // One opcode class at a time selects which fields are driven
  always_comb begin
    dec_o = '0;
    unique case (1'b1)
      is_ld: begin
        dec_o.fld.rs1       = ir_i[RA_HI:RA_LO];
        dec_o.fld.rd        = ir_i[RB_HI:RB_LO];
        dec_o.fld.imm6      = ir_i[IMM_HI:0];
        dec_o.fld.mem_read  = 1'b1;
        dec_o.fld.reg_write = 1'b1;
      end
      is_st: begin
        dec_o.fld.rs1       = ir_i[RA_HI:RA_LO];
        dec_o.fld.rs2       = ir_i[RB_HI:RB_LO];
        dec_o.fld.imm6      = ir_i[IMM_HI:0];
        dec_o.fld.mem_write = 1'b1;
      end
      is_alu: begin
        dec_o.fld.rs1       = ir_i[RA_HI:RA_LO];
        dec_o.fld.rs2       = ir_i[RB_HI:RB_LO];
        dec_o.fld.rd        = ir_i[RC_HI:RC_LO];
        dec_o.fld.alu_op    = op;
        dec_o.fld.reg_write = 1'b1;
      end
      is_br: begin
        dec_o.fld.rs1  = ir_i[RA_HI:RA_LO];
        dec_o.fld.rs2  = ir_i[RB_HI:RB_LO];
        dec_o.fld.imm6 = ir_i[IMM_HI:0];
        dec_o.is_branch = 1'b1;
        dec_o.is_bne    = (op == OP_BNE);
      end
      is_jmp: begin
        dec_o.is_jump = 1'b1;
      end
      default: begin
        dec_o.is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Fetch/decode sequencer for the 16-bit core, all outputs registered.
// ILLEGAL_TRAP_EN: illegal opcodes halt and set illegal (else NOP).
module instr_decode_ctrl
  import isa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                cmp_valid_i,
  input  logic                cmp_eq_i,
  input  logic                exec_done_i,
  instr_decode_ctrl_if.master imem,
  output logic [ILEN-1:0]     ir_o,
  output logic                uop_valid_o,
  output logic [3:0]          alu_op_o,
  output logic [2:0]          rs1_o,
  output logic [2:0]          rs2_o,
  output logic [2:0]          rd_o,
  output logic [5:0]          imm6_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                halted_o,
  output logic                illegal_o,
  output logic [15:0]         instr_count_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  state_e          state_q;
  logic [ILEN-1:0] ir_q;
  fld_t            fld_q;
  logic            is_bne_q;
  logic            uop_valid_q;
  logic            rd_instr_q;
  logic            rst_imem_q;
  logic            br_exec_q;
  logic            jmp_exec_q;
  logic [5:0]      br_off_q;
  logic [11:0]     jmp_off_q;
  logic            halted_q;
  logic            illegal_q;
  logic [15:0]     count_q;
  logic [15:0]     count_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  dec_t            dec;

  instr_field_decode u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign count_d  = count_q + 16'd1;
  assign to_cnt_d = to_cnt_q + TO_W'(1);

  // Sequencer: every output is a register updated on state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      fld_q       <= '0;
      is_bne_q    <= 1'b0;
      uop_valid_q <= 1'b0;
      rd_instr_q  <= 1'b0;
      rst_imem_q  <= 1'b0;
      br_exec_q   <= 1'b0;
      jmp_exec_q  <= 1'b0;
      br_off_q    <= '0;
      jmp_off_q   <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      count_q     <= '0;
      to_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rst_imem_q <= 1'b1;
            state_q    <= S_FETCH_CLR;
          end
        end
        S_FETCH_CLR: begin
          rst_imem_q <= 1'b0;
          rd_instr_q <= 1'b1;
          to_cnt_q   <= '0;
          state_q    <= S_FETCH_REQ;
        end
        S_FETCH_REQ: begin
          if (imem.imem_complete) begin
            ir_q       <= imem.imem_instr;
            rd_instr_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (to_cnt_q == TO_LAST) begin
            rd_instr_q <= 1'b0;
            halted_q   <= 1'b1;
            state_q    <= S_HALT;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        S_DECODE: begin
          fld_q    <= dec.fld;
          is_bne_q <= dec.is_bne;
          br_off_q <= dec.is_branch ? ir_q[IMM_HI:0] : 6'd0;
          jmp_off_q <= dec.is_jump ? ir_q[J_HI:0] : 12'd0;
          unique case (1'b1)
            dec.is_jump: begin
              jmp_exec_q <= 1'b1;
              state_q    <= S_REDIRECT;
            end
            dec.is_branch: begin
              uop_valid_q <= 1'b1;
              state_q     <= S_BR_EVAL;
            end
            dec.is_illegal: begin
`ifdef ILLEGAL_TRAP_EN
              halted_q  <= 1'b1;
              illegal_q <= 1'b1;
              state_q   <= S_HALT;
`else
              count_q    <= count_d;
              rst_imem_q <= 1'b1;
              state_q    <= S_FETCH_CLR;
`endif
            end
            default: begin
              uop_valid_q <= 1'b1;
              state_q     <= S_EXEC;
            end
          endcase
        end
        S_EXEC: begin
          if (exec_done_i) begin
            count_q     <= count_d;
            fld_q       <= '0;
            uop_valid_q <= 1'b0;
            rst_imem_q  <= 1'b1;
            state_q     <= S_FETCH_CLR;
          end
        end
        S_BR_EVAL: begin
          if (cmp_valid_i) begin
            uop_valid_q <= 1'b0;
            if (is_bne_q ^ cmp_eq_i) begin
              br_exec_q <= 1'b1;
              state_q   <= S_REDIRECT;
            end else begin
              count_q    <= count_d;
              fld_q      <= '0;
              br_off_q   <= '0;
              rst_imem_q <= 1'b1;
              state_q    <= S_FETCH_CLR;
            end
          end
        end
        S_REDIRECT: begin
          if (br_exec_q || jmp_exec_q) begin
            br_exec_q  <= 1'b0;
            jmp_exec_q <= 1'b0;
          end else if (imem.imem_pc_set) begin
            count_q    <= count_d;
            fld_q      <= '0;
            br_off_q   <= '0;
            jmp_off_q  <= '0;
            rst_imem_q <= 1'b1;
            state_q    <= S_FETCH_CLR;
          end
        end
        S_HALT: begin
          if (start_i) begin
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
            rst_imem_q <= 1'b1;
            state_q    <= S_FETCH_CLR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem.read_instruction = rd_instr_q;
  assign imem.reset_imem       = rst_imem_q;
  assign imem.branch_execute   = br_exec_q;
  assign imem.jump_execute     = jmp_exec_q;
  assign imem.branch_offset    = br_off_q;
  assign imem.jump_offset      = jmp_off_q;

  assign ir_o          = ir_q;
  assign uop_valid_o   = uop_valid_q;
  assign alu_op_o      = fld_q.alu_op;
  assign rs1_o         = fld_q.rs1;
  assign rs2_o         = fld_q.rs2;
  assign rd_o          = fld_q.rd;
  assign imm6_o        = fld_q.imm6;
  assign reg_write_o   = fld_q.reg_write;
  assign mem_read_o    = fld_q.mem_read;
  assign mem_write_o   = fld_q.mem_write;
  assign halted_o      = halted_q;
  assign illegal_o     = illegal_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl; the bench plays the
// instruction memory and datapath with hand-computed expectations.
module tb_instr_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        cmp_valid_i;
  logic        cmp_eq_i;
  logic        exec_done_i;
  logic [15:0] ir_o;
  logic        uop_valid_o;
  logic [3:0]  alu_op_o;
  logic [2:0]  rs1_o;
  logic [2:0]  rs2_o;
  logic [2:0]  rd_o;
  logic [5:0]  imm6_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        halted_o;
  logic        illegal_o;
  logic [15:0] instr_count_o;

  int total = 0;
  int bad   = 0;

  instr_decode_ctrl_if mif ();

  instr_decode_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .cmp_valid_i   (cmp_valid_i),
    .cmp_eq_i      (cmp_eq_i),
    .exec_done_i   (exec_done_i),
    .imem          (mif),
    .ir_o          (ir_o),
    .uop_valid_o   (uop_valid_o),
    .alu_op_o      (alu_op_o),
    .rs1_o         (rs1_o),
    .rs2_o         (rs2_o),
    .rd_o          (rd_o),
    .imm6_o        (imm6_o),
    .reg_write_o   (reg_write_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .halted_o      (halted_o),
    .illegal_o     (illegal_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Entered in the FETCH_CLR cycle; leaves one cycle after DECODE
  task automatic fetch(input logic [15:0] w);
    mif.imem_instr    = w;
    mif.imem_complete = 1'b0;
    tick();
    mif.imem_complete = 1'b1;
    tick();
    mif.imem_complete = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    cmp_valid_i = 1'b0;
    cmp_eq_i = 1'b0;
    exec_done_i = 1'b0;
    mif.imem_instr = '0;
    mif.imem_complete = 1'b0;
    mif.imem_pc_set = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ir", ir_o, 16'h0);
    chk("rst_cnt", instr_count_o, 16'h0);
    chk("rst_read", mif.read_instruction, 1'b0);
    chk("rst_rimem", mif.reset_imem, 1'b0);
    chk("rst_uop", uop_valid_o, 1'b0);
    chk("rst_halt", halted_o, 1'b0);
    chk("rst_ill", illegal_o, 1'b0);
    chk("rst_bex", mif.branch_execute, 1'b0);

    // ALU 0x2298 with explicit fetch latency checks
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("alu_clr", mif.reset_imem, 1'b1);
    chk("alu_clr_rd", mif.read_instruction, 1'b0);
    mif.imem_instr = 16'h2298;
    tick();
    chk("alu_req", mif.read_instruction, 1'b1);
    chk("alu_req_clr", mif.reset_imem, 1'b0);
    mif.imem_complete = 1'b1;
    tick();
    mif.imem_complete = 1'b0;
    chk("alu_ir", ir_o, 16'h2298);
    chk("alu_rd_drop", mif.read_instruction, 1'b0);
    tick();
    chk("alu_uop", uop_valid_o, 1'b1);
    chk("alu_op", alu_op_o, 4'd2);
    chk("alu_rs1", rs1_o, 3'd1);
    chk("alu_rs2", rs2_o, 3'd2);
    chk("alu_rd", rd_o, 3'd3);
    chk("alu_wr", reg_write_o, 1'b1);
    chk("alu_imm", imm6_o, 6'd0);
    cmp_valid_i = 1'b1;
    tick();
    cmp_valid_i = 1'b0;
    chk("alu_wait_cnt", instr_count_o, 16'd0);
    exec_done_i = 1'b1;
    tick();
    exec_done_i = 1'b0;
    chk("alu_ret_cnt", instr_count_o, 16'd1);
    chk("alu_next_clr", mif.reset_imem, 1'b1);
    chk("alu_uop_off", uop_valid_o, 1'b0);
    chk("alu_op_clr", alu_op_o, 4'd0);

    // LD 0x0A7F
    fetch(16'h0A7F);
    chk("ld_rs1", rs1_o, 3'd5);
    chk("ld_rd", rd_o, 3'd1);
    chk("ld_imm", imm6_o, 6'h3F);
    chk("ld_mrd", mem_read_o, 1'b1);
    chk("ld_wr", reg_write_o, 1'b1);
    chk("ld_rs2", rs2_o, 3'd0);
    exec_done_i = 1'b1;
    tick();
    exec_done_i = 1'b0;
    chk("ld_cnt", instr_count_o, 16'd2);

    // ST 0x1A7F
    fetch(16'h1A7F);
    chk("st_rs2", rs2_o, 3'd1);
    chk("st_mwr", mem_write_o, 1'b1);
    chk("st_wr", reg_write_o, 1'b0);
    chk("st_rd", rd_o, 3'd0);
    exec_done_i = 1'b1;
    tick();
    exec_done_i = 1'b0;
    chk("st_cnt", instr_count_o, 16'd3);

    // BEQ 0xB285 taken; pc_set held from redirect entry
    fetch(16'hB285);
    chk("beq_uop", uop_valid_o, 1'b1);
    chk("beq_rs1", rs1_o, 3'd1);
    chk("beq_rs2", rs2_o, 3'd2);
    chk("beq_nostrobe", mif.branch_execute, 1'b0);
    cmp_valid_i = 1'b1;
    cmp_eq_i = 1'b1;
    tick();
    cmp_valid_i = 1'b0;
    mif.imem_pc_set = 1'b1;
    chk("beq_strobe", mif.branch_execute, 1'b1);
    chk("beq_off", mif.branch_offset, 6'd5);
    tick();
    chk("beq_strobe_1cyc", mif.branch_execute, 1'b0);
    chk("beq_early_pcset", instr_count_o, 16'd3);
    chk("beq_off_hold", mif.branch_offset, 6'd5);
    tick();
    mif.imem_pc_set = 1'b0;
    chk("beq_ret", instr_count_o, 16'd4);
    chk("beq_clr", mif.reset_imem, 1'b1);

    // BEQ 0xB285 not taken
    fetch(16'hB285);
    cmp_valid_i = 1'b1;
    cmp_eq_i = 1'b0;
    tick();
    cmp_valid_i = 1'b0;
    chk("beqn_nostrobe", mif.branch_execute, 1'b0);
    chk("beqn_cnt", instr_count_o, 16'd5);
    chk("beqn_clr", mif.reset_imem, 1'b1);

    // BNE 0xC285 taken when not equal
    fetch(16'hC285);
    cmp_valid_i = 1'b1;
    cmp_eq_i = 1'b0;
    tick();
    cmp_valid_i = 1'b0;
    chk("bne_strobe", mif.branch_execute, 1'b1);
    tick();
    mif.imem_pc_set = 1'b1;
    tick();
    mif.imem_pc_set = 1'b0;
    chk("bne_cnt", instr_count_o, 16'd6);

    // JMP 0xD123
    fetch(16'hD123);
    chk("jmp_strobe", mif.jump_execute, 1'b1);
    chk("jmp_off", mif.jump_offset, 12'h123);
    chk("jmp_bex", mif.branch_execute, 1'b0);
    tick();
    chk("jmp_strobe_off", mif.jump_execute, 1'b0);
    chk("jmp_off_hold", mif.jump_offset, 12'h123);
    tick();
    tick();
    chk("jmp_wait_cnt", instr_count_o, 16'd6);
    mif.imem_pc_set = 1'b1;
    tick();
    mif.imem_pc_set = 1'b0;
    chk("jmp_cnt", instr_count_o, 16'd7);
    chk("jmp_clr", mif.reset_imem, 1'b1);

    // Illegal opcode 1111
    fetch(16'hF000);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_halt", halted_o, 1'b1);
    chk("ill_flag", illegal_o, 1'b1);
    chk("ill_cnt", instr_count_o, 16'd7);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ill_clr_flag", illegal_o, 1'b0);
    chk("ill_restart", mif.reset_imem, 1'b1);
`else
    chk("nop_cnt", instr_count_o, 16'd8);
    chk("nop_clr", mif.reset_imem, 1'b1);
    chk("nop_flag", illegal_o, 1'b0);
    chk("nop_halt", halted_o, 1'b0);
`endif

    // Fetch timeout after 8 FETCH_REQ cycles
    mif.imem_complete = 1'b0;
    tick();
    chk("to_req", mif.read_instruction, 1'b1);
    repeat (7) tick();
    chk("to_not_yet", halted_o, 1'b0);
    chk("to_rd_hold", mif.read_instruction, 1'b1);
    tick();
    chk("to_halt", halted_o, 1'b1);
    chk("to_rd_off", mif.read_instruction, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("to_restart", mif.reset_imem, 1'b1);
    chk("to_unhalt", halted_o, 1'b0);

    // Async reset while the branch strobe is high
    fetch(16'hB285);
    cmp_valid_i = 1'b1;
    cmp_eq_i = 1'b1;
    tick();
    cmp_valid_i = 1'b0;
    chk("ar_strobe", mif.branch_execute, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_drop", mif.branch_execute, 1'b0);
    chk("ar_cnt", instr_count_o, 16'd0);
    chk("ar_off", mif.branch_offset, 6'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_idle_clr", mif.reset_imem, 1'b0);
    chk("ar_idle_rd", mif.read_instruction, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ar_start", mif.reset_imem, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
